// File: rtl/jk_seq_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | jk_seq_driver_if : control, table-load and JK excitation bundle  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface jk_seq_driver_if #(
    parameter int W = 4
);
    logic         load_en;
    logic [2:0]   load_addr;
    logic [W-1:0] load_data;
    logic [2:0]   len;
    logic         loop;
    logic         start;
    logic         stop;
    logic [W-1:0] Q;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         busy;
    logic         done;
    logic         err;
    logic [2:0]   step_idx;

    modport master (
        output load_en, load_addr, load_data, len, loop, start, stop, Q,
        input  J, K, busy, done, err, step_idx
    );

    modport slave (
        input  load_en, load_addr, load_data, len, loop, start, stop, Q,
        output J, K, busy, done, err, step_idx
    );
endinterface
`default_nettype wire

// File: rtl/jk_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | jk_seq_driver : steps an external JK bank through a target table |
// | Optional macro JK_TOGGLE_EN: changing bits are driven J=K=1.     |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module jk_seq_driver #(
    parameter int W = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    jk_seq_driver_if.slave bus
);
    localparam int DEPTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   step_idx_q, step_idx_d;
    logic [2:0]   len_q, len_d;
    logic         loop_q, loop_d;
    logic         done_q, done_d;
    logic [W-1:0] tbl_q [DEPTH];
    logic [W-1:0] w_target;
    logic [W-1:0] w_diff;

    assign w_target = tbl_q[step_idx_q];
    assign w_diff   = w_target ^ bus.Q;

    // Table is deliberately outside the reset domain so a replay after reset reuses it.
    always_ff @(posedge clk) begin
        if (!rst && bus.load_en && state_q == S_IDLE) begin
            tbl_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_idx_q <= 3'd0;
            len_q      <= 3'd0;
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        len_d      = len_q;
        loop_d     = loop_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d    = S_DRIVE;
                    step_idx_d = 3'd0;
                    len_d      = bus.len;
                    loop_d     = bus.loop;
                end
            end
            S_DRIVE: begin
                state_d = bus.stop ? S_IDLE : S_CHECK;
            end
            S_CHECK: begin
                // stop outranks every comparison outcome, including a mismatch
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.Q != w_target) begin
                    state_d = S_FAULT;
                end else if (step_idx_q != len_q) begin
                    state_d    = S_DRIVE;
                    step_idx_d = step_idx_q + 3'd1;
                end else if (loop_q) begin
                    state_d    = S_DRIVE;
                    step_idx_d = 3'd0;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FAULT: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.J = '0;
        bus.K = '0;
        if (state_q == S_DRIVE && !rst) begin
`ifdef JK_TOGGLE_EN
            bus.J = w_diff;
            bus.K = w_diff;
`else
            bus.J = w_diff & w_target;
            bus.K = w_diff & ~w_target;
`endif
        end
    end

    assign bus.busy     = (state_q == S_DRIVE) || (state_q == S_CHECK);
    assign bus.done     = done_q;
    assign bus.err      = (state_q == S_FAULT);
    assign bus.step_idx = step_idx_q;
endmodule
`default_nettype wire

// File: tb/tb_jk_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for jk_seq_driver: external JK bank, step-count reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_jk_seq_driver;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_seq_driver_if #(.W(W)) bus();

    logic [W-1:0] bank_q    = '0;
    logic         force_en  = 1'b0;
    logic [W-1:0] force_val = '0;
    assign bus.Q = force_en ? force_val : bank_q;
    always @(posedge clk) bank_q <= (bus.J & ~bank_q) | (~bus.K & bank_q);

    jk_seq_driver #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference model: a sequence is a count of elapsed cycles since start;
    // even counts are drive cycles, odd counts are check cycles.
    logic [W-1:0] m_tbl [8];
    bit m_active = 0, m_fault = 0, m_done = 0, m_loop = 0;
    int m_pos = 0, m_len = 0, m_sidx = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_fault = 0; m_done = 0; m_sidx = 0; m_pos = 0;
        end else begin
            m_done = 0;
            if (m_fault) begin
                if (bus.stop) m_fault = 0;
            end else if (m_active) begin
                if (bus.stop) m_active = 0;
                else if (m_pos % 2 == 0) m_pos++;
                else if (bus.Q != m_tbl[m_sidx]) begin m_active = 0; m_fault = 1; end
                else if (!m_loop && m_pos == 2 * m_len + 1) begin m_active = 0; m_done = 1; end
                else begin
                    m_pos++;
                    m_sidx = (m_pos / 2) % (m_len + 1);
                end
            end else begin
                if (bus.load_en) m_tbl[bus.load_addr] = bus.load_data;
                if (bus.start && !bus.stop) begin
                    m_active = 1; m_pos = 0; m_sidx = 0;
                    m_len = int'(bus.len); m_loop = bus.loop;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] t, d, ej, ek;
        if (chk_en) begin
            t  = m_tbl[m_sidx];
            d  = t ^ bus.Q;
            ej = '0;
            ek = '0;
            if (m_active && (m_pos % 2 == 0) && !rst) begin
`ifdef JK_TOGGLE_EN
                ej = d; ek = d;
`else
                ej = d & t; ek = d & ~t;
`endif
            end
            chk("J", bus.J, ej);
            chk("K", bus.K, ek);
            chk("busy", bus.busy, m_active);
            chk("done", bus.done, m_done);
            chk("err", bus.err, m_fault);
            chk("step_idx", bus.step_idx, m_sidx[2:0]);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #2;
    endtask

    task automatic load(input int a, input int v);
        bus.load_en = 1'b1; bus.load_addr = 3'(a); bus.load_data = W'(v);
        nxt();
        bus.load_en = 1'b0;
    endtask

    task automatic go(input int l, input bit lp);
        bus.start = 1'b1; bus.len = 3'(l); bus.loop = lp;
        nxt();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 24 && !seen; i++) begin
            nxt();
            if (bus.done) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] qexp [4];
        int ndone;
        qexp[0] = 4'h0; qexp[1] = 4'h5; qexp[2] = 4'hA; qexp[3] = 4'hF;
        bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
        bus.len = 0; bus.loop = 0; bus.start = 0; bus.stop = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_step_idx", bus.step_idx, 0);
        chk("rst_J", bus.J, 0);
        chk("rst_K", bus.K, 0);
        #2 rst = 1'b0; chk_en = 1'b1;

        load(0, 'h0); load(1, 'h5); load(2, 'hA); load(3, 'hF);
        load(4, 'h3); load(5, 'hC); load(6, 'h6); load(7, 'h9);

        // Non-loop run: Q visits each table entry, done 8 cycles after start
        go(3, 0);
        ndone = 0;
        for (int m = 1; m <= 12; m++) begin
            if (m > 1) nxt();
            if (m % 2 == 0 && m <= 8) chk("A_q_at_check", bus.Q, qexp[m / 2 - 1]);
            if (bus.done) begin ndone++; chk("A_done_cycle", m, 9); end
        end
        chk("A_done_count", ndone, 1);
        chk("A_err", bus.err, 0);

        // Looping run, then stop in a check cycle
        go(3, 1);
        for (int m = 1; m <= 13; m++) begin
            if (m > 1) nxt();
            if (m % 2 == 1 && m <= 11) chk("B_step_idx", bus.step_idx, ((m - 1) / 2) % 4);
            chk("B_no_done", bus.done, 0);
            if (m == 12) begin chk("B_busy_before_stop", bus.busy, 1); bus.stop = 1; end
            if (m == 13) begin
                chk("B_idle_busy", bus.busy, 0);
                chk("B_idle_J", bus.J, 0);
                chk("B_idle_K", bus.K, 0);
                bus.stop = 0;
            end
        end

        // Mismatch on entry 1 -> fault, start ignored, stop clears
        go(3, 0);
        for (int m = 1; m <= 7; m++) begin
            if (m > 1) nxt();
            if (m == 3) begin force_en = 1; force_val = 4'h3; end
            if (m == 4) chk("C_no_err_yet", bus.err, 0);
            if (m == 5) begin
                chk("C_err", bus.err, 1);
                chk("C_J", bus.J, 0);
                chk("C_K", bus.K, 0);
                chk("C_busy", bus.busy, 0);
                chk("C_step_idx", bus.step_idx, 1);
                bus.start = 1;
            end
            if (m == 6) begin
                chk("C_start_ignored", bus.err, 1);
                chk("C_start_ignored_busy", bus.busy, 0);
                bus.start = 0; bus.stop = 1;
            end
            if (m == 7) begin
                chk("C_err_cleared", bus.err, 0);
                bus.stop = 0; force_en = 0;
            end
        end

        // Excitation literal: Q=6, target=9
        load(0, 'h9);
        force_en = 1; force_val = 4'h6;
        go(0, 0);
`ifdef JK_TOGGLE_EN
        chk("D_J", bus.J, 'hF);
        chk("D_K", bus.K, 'hF);
`else
        chk("D_J", bus.J, 'h9);
        chk("D_K", bus.K, 'h6);
`endif
        nxt(); nxt();
        chk("D_fault", bus.err, 1);
        bus.stop = 1; nxt(); bus.stop = 0; force_en = 0;
        load(0, 'h0);

        // Reset mid-sequence, then replay without reload
        go(3, 0);
        nxt(); nxt();
        rst = 1; nxt();
        chk("E_busy", bus.busy, 0);
        chk("E_J", bus.J, 0);
        chk("E_K", bus.K, 0);
        chk("E_step_idx", bus.step_idx, 0);
        rst = 0;
        go(3, 0);
        wait_done("E_done_seen");
        chk("E_final_q", bus.Q, 'hF);

        // start+stop together in idle; load while busy is dropped
        bus.start = 1; bus.stop = 1; nxt();
        chk("F_start_stop_idle", bus.busy, 0);
        bus.start = 0; bus.stop = 0; nxt();
        go(3, 0);
        bus.load_en = 1; bus.load_addr = 3'd2; bus.load_data = 4'h7;
        nxt();
        bus.load_en = 0;
        wait_done("F_done_seen");
        go(3, 0);
        for (int m = 2; m <= 6; m++) nxt();
        chk("F_table_kept", bus.Q, 'hA);
        wait_done("F_done_seen2");

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            nxt();
            bus.load_en   = ($urandom_range(0, 4) == 0);
            bus.load_addr = 3'($urandom_range(0, 7));
            bus.load_data = W'($urandom_range(0, 15));
            bus.start     = ($urandom_range(0, 5) == 0);
            bus.stop      = ($urandom_range(0, 19) == 0);
            bus.len       = 3'($urandom_range(0, 7));
            bus.loop      = 1'($urandom_range(0, 1));
            rst           = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) begin
                force_en  = ~force_en;
                force_val = W'($urandom_range(0, 15));
            end
        end
        bus.load_en = 0; bus.start = 0; bus.stop = 0; rst = 0; force_en = 0;
        repeat (3) nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
